timer_sched: RTL and testbench
==============================

# timer_sched

Round-robin scheduler that shares one `Timer` instance (16-bit count-up timer with `start_i`, `n_i`, `curr_time_q` and `curr_end_q`) among NREQ requesters.
- Each requester asks for a delay of `dur` cycles.
- The scheduler grants one requester at a time, loads `n_i`, and holds `start_i` through the run.
- On `curr_end_q` it returns a one-cycle done pulse to the owner, then forces one clear cycle before the next grant.
- It sits between client FSMs and the shared `Timer`.

## Interface
Parameters
- NREQ, 4: number of requesters (2..8).
- WD_SLACK, 2: watchdog margin in cycles; used only with the watchdog macro.

Ports
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  NREQ  per-requester request level; must be held high until the matching done_o.
- dur_i  in  NREQ*16  durations; requester k uses bits [16k+15:16k].
- gnt_o  out  NREQ  one-hot grant; high for the whole run.
- done_o  out  NREQ  one-cycle completion pulse to the owner.
- err_o  out  1  one-cycle watchdog error pulse, coincident with done_o.
- busy_o  out  1  high when state is not IDLE.
- tmr_start_o  out  1  drives Timer `start_i`.
- tmr_n_o  out  16  drives Timer `n_i`; holds the latched duration.
- tmr_time_i  in  16  from Timer `curr_time_q`.
- tmr_end_i  in  1  from Timer `curr_end_q`.

## Operation
- **States:** IDLE, RUN, CLEAR. All outputs are registered.
- **Reset (async):**
  - state=IDLE, gnt_o=0, done_o=0, err_o=0, tmr_start_o=0, tmr_n_o=0, busy_o=0.
  - Round-robin pointer ptr=NREQ-1, so req 0 wins first.
  - Reset mid-run abandons the run; no done_o is issued.
- **IDLE:**
  - If req_i≠0, select the first set bit searching from ptr+1 upward, wrapping modulo NREQ.
  - Latch index k; set ptr=k; latch tmr_n_o=dur_k.
  - If dur_k≠0: go to RUN with gnt_o[k]=1 and tmr_start_o=1.
  - If dur_k==0: do not run the timer. Pulse done_o[k], keep gnt_o=0, go to CLEAR.
- **RUN:**
  - Hold gnt_o, tmr_start_o and tmr_n_o stable; dur_i changes are ignored.
  - If tmr_end_i=1: pulse done_o[k], clear gnt_o and tmr_start_o, go to CLEAR.
  - Else if req_i[k]=0 (abort): clear gnt_o and tmr_start_o, go to CLEAR. No done_o.
  - If the end and the abort are sampled on the same edge, end wins and done_o is issued.
- **CLEAR:**
  - tmr_start_o=0 for exactly one cycle so the Timer returns to 0.
  - Next state is IDLE unconditionally. A new request arriving here waits.
- **Guarantees:** done_o is never asserted for more than one requester in the same cycle. gnt_o is at most one-hot.

## Timing
- A request sampled in IDLE at edge e gives gnt_o and tmr_start_o high after edge e.
- tmr_end_i sampled high at edge m:
  - done_o is high for cycle m..m+1.
  - State is IDLE after edge m+1.
  - The earliest next grant is after edge m+2.
- Back-to-back requests therefore see 2 idle cycles between runs with tmr_start_o=0; the timer is always cleared.
- A zero-duration job: done_o appears the cycle after the request is sampled, and the next grant comes 2 edges later.
- Fairness: with all requesters continuously active, grants rotate 0,1,…,NREQ-1,0,…

## Configuration
- **TIMER_SCHED_WATCHDOG_EN defined:**
  - In RUN, if tmr_end_i=0 and tmr_time_i ≥ tmr_n_o+WD_SLACK (17-bit compare, no wrap), the run is forced to finish.
  - Forced finish: done_o[k]=1 and err_o=1 for one cycle, clear gnt_o and tmr_start_o, go to CLEAR.
- **TIMER_SCHED_WATCHDOG_EN undefined:**
  - err_o is tied to 0.
  - RUN waits indefinitely for tmr_end_i or an abort.

## Test plan
- **Reset values:** rst_n low → all outputs 0. Then req_i=4'b0001, dur0=20 → gnt_o=0001, tmr_n_o=20, tmr_start_o=1. done_o[0] pulses the cycle after tmr_end_i, then 2 idle cycles.
- **Rotation:** req_i=4'b1111, all durations 5 → grant order 0,1,2,3,0. Exactly one done pulse per run; gnt_o never has two bits set.
- **Zero duration:** dur2=0, req_i=4'b0100 → done_o[2] pulses with gnt_o=0 and tmr_start_o=0 throughout.
- **Abort:** req1 dropped mid-run with dur1=30 → gnt_o and tmr_start_o drop next edge, no done_o[1]. req3 pending at that time is granted 2 edges later.
- **Simultaneous end and abort:** tmr_end_i=1 and req_i[k]=0 on the same edge → done_o[k] is issued.
- **Watchdog and async reset:** with the macro defined, tie tmr_end_i=0, dur=10 → done_o and err_o pulse together when tmr_time_i reaches 12. Async reset during RUN → outputs 0 immediately, ptr back to NREQ-1.

Source files
------------

// File: rtl/timer_sched_if.sv
// Requester and Timer-facing bundle of timer_sched; the scheduler uses the slave modport.
interface timer_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_i;
    logic [NREQ*16-1:0] dur_i;
    logic [NREQ-1:0]    gnt_o;
    logic [NREQ-1:0]    done_o;
    logic               err_o;
    logic               busy_o;
    logic               tmr_start_o;
    logic [15:0]        tmr_n_o;
    logic [15:0]        tmr_time_i;
    logic               tmr_end_i;

    modport slave (
        input  req_i, dur_i, tmr_time_i, tmr_end_i,
        output gnt_o, done_o, err_o, busy_o, tmr_start_o, tmr_n_o
    );

    modport master (
        output req_i, dur_i, tmr_time_i, tmr_end_i,
        input  gnt_o, done_o, err_o, busy_o, tmr_start_o, tmr_n_o
    );
endinterface

// File: rtl/timer_sched.sv
// Purpose: round-robin sharing of one 16-bit Timer among NREQ requesters (watchdog: TIMER_SCHED_WATCHDOG_EN).
// Latency: grant one edge after the request is sampled; done one edge after tmr_end_i; 2 idle cycles between runs.
// Backpressure: requesters hold req_i until done_o; dropping req_i mid-run aborts without done_o.
module timer_sched #(
    parameter int NREQ     = 4,
    parameter int WD_SLACK = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    timer_sched_if.slave  bus
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    state_t          state_q, state_n;
    logic [PW-1:0]   ptr_q, ptr_n;
    logic [PW-1:0]   idx_q, idx_n;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic [NREQ-1:0] done_q, done_n;
    logic            err_q, err_n;
    logic            busy_q, busy_n;
    logic            start_q, start_n;
    logic [15:0]     n_q, n_n;

    logic            found;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   cand;
    logic [15:0]     sel_dur;
    logic            wd_hit;

    // Search upward from ptr+1, wrapping, so the last winner has lowest priority.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign sel_dur = bus.dur_i[int'(sel)*16 +: 16];

`ifdef TIMER_SCHED_WATCHDOG_EN
    assign wd_hit = !bus.tmr_end_i &&
                    ({1'b0, bus.tmr_time_i} >= ({1'b0, n_q} + 17'(WD_SLACK)));
`else
    logic wd_unused;
    assign wd_hit    = 1'b0;
    assign wd_unused = (17'(WD_SLACK) != 17'd0) ^ (^bus.tmr_time_i);
`endif

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        idx_n   = idx_q;
        gnt_n   = gnt_q;
        done_n  = '0;
        err_n   = 1'b0;
        start_n = start_q;
        n_n     = n_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ptr_n = sel;
                    idx_n = sel;
                    n_n   = sel_dur;
                    if (sel_dur != 16'd0) begin
                        gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << sel;
                        start_n = 1'b1;
                        state_n = RUN;
                    end else begin
                        // Zero-length job completes without touching the Timer.
                        done_n  = {{(NREQ-1){1'b0}}, 1'b1} << sel;
                        state_n = CLEAR;
                    end
                end
            end
            RUN: begin
                if (bus.tmr_end_i || wd_hit) begin
                    done_n[idx_q] = 1'b1;
                    err_n         = wd_hit;
                    gnt_n         = '0;
                    start_n       = 1'b0;
                    state_n       = CLEAR;
                end else if (!bus.req_i[idx_q]) begin
                    gnt_n   = '0;
                    start_n = 1'b0;
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                gnt_n   = '0;
                start_n = 1'b0;
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                start_n = 1'b0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            n_q     <= '0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            idx_q   <= idx_n;
            gnt_q   <= gnt_n;
            done_q  <= done_n;
            err_q   <= err_n;
            busy_q  <= busy_n;
            start_q <= start_n;
            n_q     <= n_n;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.done_o      = done_q;
    assign bus.busy_o      = busy_q;
    assign bus.tmr_start_o = start_q;
    assign bus.tmr_n_o     = n_q;
`ifdef TIMER_SCHED_WATCHDOG_EN
    assign bus.err_o       = err_q;
`else
    logic err_unused;
    assign bus.err_o       = 1'b0;
    assign err_unused      = err_q;
`endif
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: Timer inputs are driven by hand, expected values are hand-computed.
module tb_timer_sched;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    timer_sched_if #(.NREQ(4)) bus ();

    timer_sched #(.NREQ(4), .WD_SLACK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dur(input int k, input logic [15:0] v);
        bus.dur_i[16*k +: 16] = v;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".gnt"},   32'(bus.gnt_o), 32'h0);
        chk({tag, ".done"},  32'(bus.done_o), 32'h0);
        chk({tag, ".start"}, 32'(bus.tmr_start_o), 32'h0);
        chk({tag, ".err"},   32'(bus.err_o), 32'h0);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst_n          = 1'b0;
        bus.req_i      = '0;
        bus.dur_i      = '0;
        bus.tmr_time_i = '0;
        bus.tmr_end_i  = 1'b0;

        // Reset values
        #1;
        chk_quiet("rst");
        chk("rst.busy", 32'(bus.busy_o), 32'h0);
        chk("rst.n",    32'(bus.tmr_n_o), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick();
        chk_quiet("post_rst");

        // Single run: req0, dur 20
        bus.req_i = 4'b0001;
        set_dur(0, 16'd20);
        tick();
        chk("r0.gnt",   32'(bus.gnt_o), 32'h1);
        chk("r0.n",     32'(bus.tmr_n_o), 32'd20);
        chk("r0.start", 32'(bus.tmr_start_o), 32'h1);
        chk("r0.busy",  32'(bus.busy_o), 32'h1);
        tick(3);
        chk("r0.hold",  32'(bus.gnt_o), 32'h1);
        bus.tmr_end_i = 1'b1;
        tick();
        chk("r0.done",  32'(bus.done_o), 32'h1);
        chk("r0.gnt_off", 32'(bus.gnt_o), 32'h0);
        chk("r0.start_off", 32'(bus.tmr_start_o), 32'h0);
        chk("r0.busy_clr", 32'(bus.busy_o), 32'h1);
        bus.tmr_end_i = 1'b0;
        bus.req_i     = 4'b0000;
        tick();
        chk_quiet("r0.idle1");
        chk("r0.busy_idle", 32'(bus.busy_o), 32'h0);
        tick();
        chk_quiet("r0.idle2");

        // Reset again so the rotation starts from requester 0
        rst_n = 1'b0;
        #1;
        chk_quiet("rst2");
        tick();
        rst_n = 1'b1;

        // Rotation with all requesters active
        for (int k = 0; k < 4; k++) set_dur(k, 16'd5);
        bus.req_i = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            tick();
            chk($sformatf("rot%0d.gnt", r),   32'(bus.gnt_o), 32'(4'b0001 << (r % 4)));
            chk($sformatf("rot%0d.n", r),     32'(bus.tmr_n_o), 32'd5);
            chk($sformatf("rot%0d.start", r), 32'(bus.tmr_start_o), 32'h1);
            bus.tmr_end_i = 1'b1;
            tick();
            chk($sformatf("rot%0d.done", r),  32'(bus.done_o), 32'(4'b0001 << (r % 4)));
            chk($sformatf("rot%0d.gnt0", r),  32'(bus.gnt_o), 32'h0);
            bus.tmr_end_i = 1'b0;
            if (r == 4) bus.req_i = 4'b0000;
            tick();
            chk_quiet($sformatf("rot%0d.idle", r));
        end

        // Zero duration job on requester 2
        set_dur(2, 16'd0);
        bus.req_i = 4'b0100;
        tick();
        chk("z.done",  32'(bus.done_o), 32'h4);
        chk("z.gnt",   32'(bus.gnt_o), 32'h0);
        chk("z.start", 32'(bus.tmr_start_o), 32'h0);
        chk("z.busy",  32'(bus.busy_o), 32'h1);
        bus.req_i = 4'b0000;
        tick();
        chk_quiet("z.clr");
        tick();
        chk_quiet("z.idle");

        // Abort of requester 1 while requester 3 waits
        set_dur(1, 16'd30);
        set_dur(3, 16'd7);
        bus.req_i = 4'b0010;
        tick();
        chk("ab.gnt", 32'(bus.gnt_o), 32'h2);
        chk("ab.n",   32'(bus.tmr_n_o), 32'd30);
        bus.req_i = 4'b1010;
        set_dur(1, 16'd99);
        tick(2);
        chk("ab.hold_gnt", 32'(bus.gnt_o), 32'h2);
        chk("ab.hold_n",   32'(bus.tmr_n_o), 32'd30);
        bus.req_i = 4'b1000;
        tick();
        chk_quiet("ab.drop");
        tick();
        chk_quiet("ab.clr");
        tick();
        chk("ab.next_gnt", 32'(bus.gnt_o), 32'h8);
        chk("ab.next_n",   32'(bus.tmr_n_o), 32'd7);

        // End and abort on the same edge: end wins
        bus.tmr_end_i = 1'b1;
        bus.req_i     = 4'b0000;
        tick();
        chk("ea.done", 32'(bus.done_o), 32'h8);
        chk("ea.gnt",  32'(bus.gnt_o), 32'h0);
        bus.tmr_end_i = 1'b0;
        tick(2);
        chk_quiet("ea.idle");

        // Watchdog: Timer never ends, dur 10, slack 2
        set_dur(0, 16'd10);
        bus.req_i = 4'b0001;
        tick();
        chk("wd.gnt", 32'(bus.gnt_o), 32'h1);
        bus.tmr_time_i = 16'd11;
        tick();
        chk("wd.t11_done", 32'(bus.done_o), 32'h0);
        chk("wd.t11_gnt",  32'(bus.gnt_o), 32'h1);
        bus.tmr_time_i = 16'd12;
        tick();
`ifdef TIMER_SCHED_WATCHDOG_EN
        chk("wd.done", 32'(bus.done_o), 32'h1);
        chk("wd.err",  32'(bus.err_o), 32'h1);
        chk("wd.gnt0", 32'(bus.gnt_o), 32'h0);
        bus.req_i      = 4'b0000;
        bus.tmr_time_i = 16'd0;
        tick();
        chk_quiet("wd.after");
`else
        chk("wd.no_done", 32'(bus.done_o), 32'h0);
        chk("wd.no_err",  32'(bus.err_o), 32'h0);
        chk("wd.still",   32'(bus.gnt_o), 32'h1);
        bus.req_i      = 4'b0000;
        bus.tmr_time_i = 16'd0;
        tick();
        chk_quiet("wd.abort");
`endif
        tick();
        chk_quiet("wd.idle");

        // Async reset in the middle of a run
        set_dur(2, 16'd9);
        bus.req_i = 4'b0100;
        tick();
        chk("ar.gnt", 32'(bus.gnt_o), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("ar.rst");
        chk("ar.busy", 32'(bus.busy_o), 32'h0);
        chk("ar.n",    32'(bus.tmr_n_o), 32'h0);
        for (int k = 0; k < 4; k++) set_dur(k, 16'd3);
        bus.req_i = 4'b1111;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar.ptr_gnt", 32'(bus.gnt_o), 32'h1);
        bus.req_i = 4'b0000;
        tick(3);
        chk_quiet("ar.end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
